adder_accum_ctrl: RTL and testbench

Sequential operand/accumulator controller that sits directly upstream of the 16-bit carry-lookahead adder and also consumes its outputs. It latches operand B from the switches, drives both adder operands and the carry-in, waits a fixed settle time, and then captures the adder sum back into accumulator A. It also keeps a sticky overflow/borrow flag. This is the register-and-control stage of the board-level adder lab datapath.

---
 rtl/adder_accum_ctrl.sv | 144 ++++++++++++++
 tb/tb_adder_accum_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accum_ctrl.sv
// Operand/accumulator controller for the 16-bit lookahead adder lab.
// Latches B, drives the adder, waits to settle, then captures Sum into A.
module adder_accum_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Sub,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout_in,
  output logic [WIDTH-1:0] A_op,
  output logic [WIDTH-1:0] B_op,
  output logic             Cin,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Ovf
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    WAIT_REL
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] a, a_d;
  logic [WIDTH-1:0] b, b_d;
  logic             sub_q, sub_d;
  logic             ovf, ovf_d;
  logic             done, done_d;
  logic             clr_pend, clr_pend_d;
  logic [3:0]       cnt, cnt_d;

  logic run_s1, run_s2, run_prev;
  logic clr_s1, clr_s2, clr_prev;
  logic run_edge, clr_edge;

  // Sync flops reset high so a button held through reset gives no edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_s1   <= 1'b1;
      run_s2   <= 1'b1;
      run_prev <= 1'b1;
      clr_s1   <= 1'b1;
      clr_s2   <= 1'b1;
      clr_prev <= 1'b1;
    end else begin
      run_s1   <= Run;
      run_s2   <= run_s1;
      run_prev <= run_s2;
      clr_s1   <= ClearA_LoadB;
      clr_s2   <= clr_s1;
      clr_prev <= clr_s2;
    end
  end

  assign run_edge = run_s2 & ~run_prev;
  assign clr_edge = clr_s2 & ~clr_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      sub_q    <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      clr_pend <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      a        <= a_d;
      b        <= b_d;
      sub_q    <= sub_d;
      ovf      <= ovf_d;
      done     <= done_d;
      clr_pend <= clr_pend_d;
      cnt      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    a_d        = a;
    b_d        = b;
    sub_d      = sub_q;
    ovf_d      = ovf;
    done_d     = 1'b0;
    clr_pend_d = 1'b0;
    cnt_d      = cnt;
    unique case (state)
      IDLE: begin
        // A clear edge blocks any Run edge until the load lands.
        if (clr_pend) begin
          a_d   = '0;
          b_d   = SW;
          ovf_d = 1'b0;
        end else if (clr_edge) begin
          clr_pend_d = 1'b1;
        end else if (run_edge) begin
          sub_d   = Sub;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        a_d     = Sum;
        ovf_d   = ovf | (sub_q ? ~Cout_in : Cout_in);
        done_d  = 1'b1;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!run_s2) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A_op   = a;
  assign B_op   = sub_q ? ~b : b;
  assign Cin    = sub_q;
  assign Result = a;
  assign Busy   = (state != IDLE);
  assign Done   = done;
  assign Ovf    = ovf;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Directed bench for adder_accum_ctrl with a behavioural adder in the loop.
// Table rows drive load/add/sub operations; hand sequences cover corners.
module tb_adder_accum_ctrl;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] SW;
  logic         Run;
  logic         ClearA_LoadB;
  logic         Sub;
  logic [W-1:0] Sum;
  logic         Cout_in;
  logic [W-1:0] A_op;
  logic [W-1:0] B_op;
  logic         Cin;
  logic [W-1:0] Result;
  logic         Busy;
  logic         Done;
  logic         Ovf;

  logic [W:0]   full;

  adder_accum_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SW           (SW),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Sub          (Sub),
    .Sum          (Sum),
    .Cout_in      (Cout_in),
    .A_op         (A_op),
    .B_op         (B_op),
    .Cin          (Cin),
    .Result       (Result),
    .Busy         (Busy),
    .Done         (Done),
    .Ovf          (Ovf)
  );

  // The external carry-lookahead adder.
  assign full    = {1'b0, A_op} + {1'b0, B_op} + {{W{1'b0}}, Cin};
  assign Sum     = full[W-1:0];
  assign Cout_in = full[W];

  always #5 Clk = ~Clk;

  typedef struct {
    int           op;
    logic [W-1:0] sw;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  localparam int OP_LOAD = 0;
  localparam int OP_ADD  = 1;
  localparam int OP_SUB  = 2;

  vec_t tbl[12];

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] a_m;
  logic [W-1:0] b_m;
  logic         cur_sub;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [W-1:0] sw);
    logic [W-1:0] bexp;
    SW           = sw;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    step();
    step();
    step();
    bexp = cur_sub ? ~sw : sw;
    check("load_result", 32'(Result), 32'h0);
    check("load_bop", 32'(B_op), 32'(bexp));
    check("load_ovf", 32'(Ovf), 32'h0);
    check("load_busy", 32'(Busy), 32'h0);
    a_m = '0;
    b_m = sw;
  endtask

  task automatic do_run(input logic sub, input logic [W-1:0] exp_res,
                        input logic exp_ovf);
    logic [W-1:0] bexp;
    Sub = sub;
    Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    check("run_busy_e1", 32'(Busy), 32'h0);
    step();
    bexp = sub ? ~b_m : b_m;
    check("settle_busy", 32'(Busy), 32'h1);
    check("settle_aop", 32'(A_op), 32'(a_m));
    check("settle_bop", 32'(B_op), 32'(bexp));
    check("settle_cin", 32'(Cin), 32'(sub));
    step();
    step();
    check("capture_done_early", 32'(Done), 32'h0);
    check("capture_result_early", 32'(Result), 32'(a_m));
    step();
    check("run_result", 32'(Result), 32'(exp_res));
    check("run_done", 32'(Done), 32'h1);
    check("run_ovf", 32'(Ovf), 32'(exp_ovf));
    step();
    check("run_done_clr", 32'(Done), 32'h0);
    check("run_busy_end", 32'(Busy), 32'h0);
    a_m     = exp_res;
    cur_sub = sub;
  endtask

  initial begin
    int dones;

    tbl[0]  = '{OP_LOAD, 16'h1234, 16'h0000, 1'b0};
    tbl[1]  = '{OP_ADD,  16'h0000, 16'h1234, 1'b0};
    tbl[2]  = '{OP_ADD,  16'h0000, 16'h2468, 1'b0};
    tbl[3]  = '{OP_LOAD, 16'h8000, 16'h0000, 1'b0};
    tbl[4]  = '{OP_ADD,  16'h0000, 16'h8000, 1'b0};
    tbl[5]  = '{OP_ADD,  16'h0000, 16'h0000, 1'b1};
    tbl[6]  = '{OP_ADD,  16'h0000, 16'h8000, 1'b1};
    tbl[7]  = '{OP_LOAD, 16'h8000, 16'h0000, 1'b0};
    tbl[8]  = '{OP_LOAD, 16'h0001, 16'h0000, 1'b0};
    tbl[9]  = '{OP_SUB,  16'h0000, 16'hFFFF, 1'b1};
    tbl[10] = '{OP_ADD,  16'h0000, 16'h0000, 1'b1};
    tbl[11] = '{OP_ADD,  16'h0000, 16'h0001, 1'b1};

    Reset        = 1'b1;
    SW           = '0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    Sub          = 1'b0;
    a_m          = '0;
    b_m          = '0;
    cur_sub      = 1'b0;
    step();
    step();
    check("rst_aop", 32'(A_op), 32'h0);
    check("rst_bop", 32'(B_op), 32'h0);
    check("rst_cin", 32'(Cin), 32'h0);
    check("rst_result", 32'(Result), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_ovf", 32'(Ovf), 32'h0);
    Reset = 1'b0;
    step();
    step();
    check("idle_busy", 32'(Busy), 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].op == OP_LOAD) begin
        do_load(tbl[i].sw);
      end else begin
        do_run(tbl[i].op == OP_SUB, tbl[i].res, tbl[i].ovf);
      end
    end

    // Held button: one add, one Done, Busy until sync sees release.
    Sub   = 1'b0;
    Run   = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (Done) dones++;
    end
    check("held_dones", 32'(dones), 32'h1);
    check("held_result", 32'(Result), 32'h0002);
    check("held_busy", 32'(Busy), 32'h1);
    Run = 1'b0;
    step();
    check("rel_busy_e0", 32'(Busy), 32'h1);
    step();
    check("rel_busy_e1", 32'(Busy), 32'h1);
    step();
    check("rel_busy_e2", 32'(Busy), 32'h0);
    a_m = 16'h0002;

    // Clear pulse while busy is ignored with no deferred effect.
    Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    step();
    SW           = 16'hAAAA;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("ign_result", 32'(Result), 32'h0003);
    check("ign_bop", 32'(B_op), 32'h0001);
    check("ign_busy", 32'(Busy), 32'h0);
    a_m = 16'h0003;
    do_run(1'b0, 16'h0004, 1'b1);

    // Simultaneous Run and Clear edges: load wins.
    SW           = 16'h5555;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    step();
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    dones        = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (Busy) dones++;
    end
    check("sim_busy_cycles", 32'(dones), 32'h0);
    check("sim_result", 32'(Result), 32'h0);
    check("sim_bop", 32'(B_op), 32'h5555);
    check("sim_ovf", 32'(Ovf), 32'h0);
    a_m = '0;
    b_m = 16'h5555;
    do_run(1'b1, 16'hAAAB, 1'b1);

    // Reset in SETTLE with Run held high.
    Sub = 1'b0;
    Run = 1'b1;
    step();
    step();
    step();
    check("mid_busy", 32'(Busy), 32'h1);
    Reset = 1'b1;
    step();
    check("mid_rst_result", 32'(Result), 32'h0);
    check("mid_rst_bop", 32'(B_op), 32'h0);
    check("mid_rst_cin", 32'(Cin), 32'h0);
    check("mid_rst_busy", 32'(Busy), 32'h0);
    check("mid_rst_done", 32'(Done), 32'h0);
    check("mid_rst_ovf", 32'(Ovf), 32'h0);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Busy || Done) dones++;
    end
    check("post_rst_idle", 32'(dones), 32'h0);
    check("post_rst_result", 32'(Result), 32'h0);
    Run = 1'b0;
    step();
    step();
    step();
    a_m     = '0;
    b_m     = '0;
    cur_sub = 1'b0;
    do_run(1'b0, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
